// File: rtl/trimat_inv_sched.sv
// Round-robin scheduler that shares one 3x3 upper-triangular inverse array among NREQ requesters.
// Optional performance counters are built when TRIMAT_SCHED_PERF_EN is defined.

module trimat_inv_sched #(
  parameter int DWIDTH  = 32,
  parameter int MATSIZE = 3,
  parameter int NREQ    = 2,
  parameter int LATENCY = 10,
  parameter int IDW     = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NREQ-1:0]                         req_valid,
  output logic [NREQ-1:0]                         req_ready,
  input  logic [NREQ*MATSIZE*MATSIZE*DWIDTH-1:0]  req_mat,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [MATSIZE*MATSIZE*DWIDTH-1:0]       res_mat,
  output logic [IDW-1:0]                          res_id,
  output logic                                    res_err,
  output logic                                    inv_vld,
  output logic                                    inv_en,
  output logic [MATSIZE*MATSIZE*DWIDTH-1:0]       inv_mat_in,
  input  logic [MATSIZE*MATSIZE*DWIDTH-1:0]       inv_mat_out,
  output logic [15:0]                             perf_jobs,
  output logic [31:0]                             perf_busy
);

  localparam int MW = MATSIZE * MATSIZE * DWIDTH;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DIAG_STEP = (MATSIZE + 1) * DWIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last_grant;
  logic [MW-1:0]   hold;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [SW-1:0]   idx;
  logic            found;
  logic [MW-1:0]   sel_mat;
  logic            pivot_zero;
  logic            take;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every signal gets a default before the loop; a path that skips an assignment would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = SW'((int'(last_grant) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_mat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) sel_mat = req_mat[k*MW +: MW];
    end
  end

  // Magnitude bits only, so both +0 and -0 count as a zero pivot.
  assign pivot_zero = ~|sel_mat[0 +: DWIDTH-1]
                    | ~|sel_mat[DIAG_STEP +: DWIDTH-1]
                    | ~|sel_mat[2*DIAG_STEP +: DWIDTH-1];

  assign req_ready  = (rst_n && state == S_IDLE) ? grant : '0;
  assign take       = |req_ready;

  assign inv_vld    = (state == S_RUN) || (state == S_CAPT);
  assign inv_en     = (state == S_RUN);
  assign res_valid  = (state == S_DONE);
  assign inv_mat_in = hold;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= IDW'(NREQ - 1);
      // NOTE: this wide data register is reset only because inv_mat_in has a defined reset value.
      hold       <= '0;
      res_mat    <= '0;
      res_id     <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            hold       <= sel_mat;
            res_id     <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= '0;
            if (pivot_zero) begin
              res_err <= 1'b1;
              res_mat <= '0;
              state   <= S_DONE;
            end else begin
              res_err <= 1'b0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LATENCY - 1)) state <= S_CAPT;
        end
        S_CAPT: begin
          res_mat <= inv_mat_out;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TRIMAT_SCHED_PERF_EN
  logic [15:0] jobs_q;
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jobs_q <= '0;
      busy_q <= '0;
    end else begin
      if (res_valid && res_ready && jobs_q != 16'hFFFF) jobs_q <= jobs_q + 16'd1;
      if (state != S_IDLE) busy_q <= busy_q + 32'd1;
    end
  end

  assign perf_jobs = jobs_q;
  assign perf_busy = busy_q;
`else
  assign perf_jobs = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_trimat_inv_sched.sv
// Self-checking bench for trimat_inv_sched: directed scenarios plus a randomized run
// against a transaction-level reference model and a behavioural stand-in for the inverse array.

module tb_trimat_inv_sched;

  localparam int DW   = 32;
  localparam int NREQ = 2;
  localparam int LAT  = 10;
  localparam int IDW  = 2;
  localparam int MW   = 9 * DW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*MW-1:0]   req_mat;
  logic                 res_valid;
  logic                 res_ready;
  logic [MW-1:0]        res_mat;
  logic [IDW-1:0]       res_id;
  logic                 res_err;
  logic                 inv_vld;
  logic                 inv_en;
  logic [MW-1:0]        inv_mat_in;
  logic [MW-1:0]        inv_mat_out;
  logic [15:0]          perf_jobs;
  logic [31:0]          perf_busy;

  int checks   = 0;
  int failures = 0;
  int last     = NREQ - 1;   // reference round-robin pointer

  always #5 clk = ~clk;

  trimat_inv_sched #(
    .DWIDTH(DW), .MATSIZE(3), .NREQ(NREQ), .LATENCY(LAT), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mat(req_mat),
    .res_valid(res_valid), .res_ready(res_ready), .res_mat(res_mat),
    .res_id(res_id), .res_err(res_err),
    .inv_vld(inv_vld), .inv_en(inv_en), .inv_mat_in(inv_mat_in), .inv_mat_out(inv_mat_out),
    .perf_jobs(perf_jobs), .perf_busy(perf_busy)
  );

  // Stand-in array: reciprocal exponent on the diagonal, sign-flipped off-diagonals,
  // valid only after LAT enabled cycles since vld rose; garbage before that.
  function automatic logic [MW-1:0] array_fn(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic [DW-1:0] x;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      x = m[i*DW +: DW];
      if (i % 4 == 0)            r[i*DW +: DW] = {x[31], 8'(8'd254 - x[30:23]), x[22:0]};
      else if (x[30:0] != 31'd0) r[i*DW +: DW] = {~x[31], x[30:0]};
    end
    return r;
  endfunction

  int arr_cnt = 0;
  always @(posedge clk) begin
    if (!inv_vld)    arr_cnt <= 0;
    else if (inv_en) arr_cnt <= arr_cnt + 1;
  end
  assign inv_mat_out = (arr_cnt >= LAT) ? array_fn(inv_mat_in)
                                        : {9{32'hBAD0_0000 | 32'(arr_cnt)}};

  function automatic bit pivot_bad(input logic [MW-1:0] m);
    logic [DW-1:0] a, d, f;
    a = m[0 +: DW];
    d = m[4*DW +: DW];
    f = m[8*DW +: DW];
    return (a[30:0] == 31'd0) || (d[30:0] == 31'd0) || (f[30:0] == 31'd0);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int from);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(from + i) % NREQ]) return (from + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [MW-1:0] rand_mat(input bit allow_zero);
    logic [MW-1:0] m;
    logic [DW-1:0] x;
    for (int i = 0; i < 9; i++) begin
      x = $urandom;
      if (i % 4 == 0 && x[30:0] == 31'd0) x = 32'h3F80_0000;
      m[i*DW +: DW] = x;
    end
    if (allow_zero && $urandom_range(0, 5) == 0)
      m[$urandom_range(0, 2)*4*DW +: DW] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_mat   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last  = NREQ - 1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    req_mat   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++;
    if ({inv_vld, inv_en, res_valid, res_err, res_id} !== '0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0", {inv_vld, inv_en, res_valid, res_err, res_id});
    end
    checks++;
    if (res_mat !== '0) begin failures++; $display("FAIL reset_res_mat: got %h expected 0", res_mat); end
    checks++;
    if (inv_mat_in !== '0) begin failures++; $display("FAIL reset_inv_mat_in: got %h expected 0", inv_mat_in); end
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    last = NREQ - 1;
  endtask

  task automatic test_single_job();
    logic [MW-1:0] m, exp_mat;
    int vld_n, en_n, k;
    do_reset();
    m = '0;
    m[0 +: DW] = 32'h4000_0000;      // 2.0
    m[4*DW +: DW] = 32'h4080_0000;   // 4.0
    m[8*DW +: DW] = 32'h4100_0000;   // 8.0
    exp_mat = '0;
    exp_mat[0 +: DW] = 32'h3F00_0000;
    exp_mat[4*DW +: DW] = 32'h3E80_0000;
    exp_mat[8*DW +: DW] = 32'h3E00_0000;
    req_mat[0 +: MW] = m;
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    vld_n = 0; en_n = 0; k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (inv_vld) vld_n++;
      if (inv_en) en_n++;
      if (res_valid) break;
      tick();
      k++;
    end
    checks++;
    if (k !== LAT + 1) begin failures++; $display("FAIL single_latency: got %0d expected %0d", k, LAT + 1); end
    checks++;
    if (vld_n !== LAT + 1) begin failures++; $display("FAIL single_vld_cycles: got %0d expected %0d", vld_n, LAT + 1); end
    checks++;
    if (en_n !== LAT) begin failures++; $display("FAIL single_en_cycles: got %0d expected %0d", en_n, LAT); end
    checks++;
    if ({res_id, res_err} !== 3'b000) begin failures++; $display("FAIL single_id_err: got %b expected 000", {res_id, res_err}); end
    checks++;
    if (res_mat !== exp_mat) begin failures++; $display("FAIL single_res_mat: got %h expected %h", res_mat, exp_mat); end
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL single_res_drop: got %b expected 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_alternate();
    logic [NREQ-1:0] oh;
    int exp_g, grants;
    do_reset();
    for (int k = 0; k < NREQ; k++) req_mat[k*MW +: MW] = rand_mat(0);
    req_valid = '1;
    res_ready = 1'b1;
    exp_g = 0;
    grants = 0;
    for (int c = 0; c < 200 && grants < 4; c++) begin
      @(negedge clk);
      checks++;
      if ((req_ready & (req_ready - 1'b1)) !== '0) begin
        failures++; $display("FAIL alt_onehot: got %b expected at most one bit", req_ready);
      end
      checks++;
      if ((inv_vld || res_valid) && req_ready !== '0) begin
        failures++; $display("FAIL alt_busy_ready: got %b expected 0", req_ready);
      end
      if (req_ready !== '0) begin
        oh = '0;
        oh[exp_g] = 1'b1;
        checks++;
        if (req_ready !== oh) begin failures++; $display("FAIL alt_order: got %b expected %b", req_ready, oh); end
        exp_g = (exp_g + 1) % NREQ;
        grants++;
      end
      tick();
    end
    checks++;
    if (grants !== 4) begin failures++; $display("FAIL alt_timeout: got %0d grants expected 4", grants); end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    logic [MW-1:0] ma, mb;
    int k;
    do_reset();
    ma = rand_mat(0);
    mb = rand_mat(0);
    req_mat = {mb, ma};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 30) begin
      tick();
      @(negedge clk);
      k++;
    end
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout: got res_valid %b expected 1", res_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, res_id, res_err, res_mat} !== {1'b1, 2'd0, 1'b0, array_fn(ma)}) begin
        failures++; $display("FAIL bp_hold: got v=%b id=%0d err=%b mat=%h", res_valid, res_id, res_err, res_mat);
      end
      checks++;
      if (req_ready !== '0) begin failures++; $display("FAIL bp_ready: got %b expected 0", req_ready); end
      tick();
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || res_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release: got ready=%b valid=%b expected 00/1", req_ready, res_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({res_valid, req_ready} !== 3'b010) begin
      failures++; $display("FAIL bp_next_grant: got %b expected 010", {res_valid, req_ready});
    end
    res_ready = 1'b0;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({inv_vld, res_id} !== 3'b101 || inv_mat_in !== mb) begin
      failures++; $display("FAIL bp_second_job: got vld=%b id=%0d in=%h", inv_vld, res_id, inv_mat_in);
    end
  endtask

  task automatic test_reject();
    logic [MW-1:0] m1, m0;
    do_reset();
    m1 = rand_mat(0);
    m1[4*DW +: DW] = 32'h8000_0000;
    req_mat = {m1, rand_mat(0)};
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL rej_grant: got %b expected 10", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_err, res_id, inv_vld} !== 5'b11010 || res_mat !== '0) begin
        failures++; $display("FAIL rej_result: got v=%b err=%b id=%0d vld=%b mat=%h",
                             res_valid, res_err, res_id, inv_vld, res_mat);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    // Second rejection on requester 0 must still move the pointer past it.
    m0 = rand_mat(0);
    m0[0 +: DW] = 32'h0;
    req_mat[0 +: MW] = m0;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({res_valid, res_err, res_id} !== 4'b1100) begin
      failures++; $display("FAIL rej_req0: got %b expected 1100", {res_valid, res_err, res_id});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL rej_rr_advance: got %b expected 10", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset();
    req_mat[0 +: MW] = rand_mat(0);
    req_valid = 2'b01;
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if ({inv_vld, inv_en, res_valid} !== 3'b110) begin
      failures++; $display("FAIL mrst_running: got %b expected 110", {inv_vld, inv_en, res_valid});
    end
    rst_n = 1'b0;
    req_valid = '1;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL mrst_ready: got %b expected 0", req_ready); end
    checks++;
    if ({inv_vld, inv_en, res_valid, res_err, res_id} !== '0 || res_mat !== '0 || inv_mat_in !== '0) begin
      failures++; $display("FAIL mrst_outputs: got ctrl=%b mat=%h in=%h",
                           {inv_vld, inv_en, res_valid, res_err, res_id}, res_mat, inv_mat_in);
    end
    rst_n = 1'b1;
    last = NREQ - 1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL mrst_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 30) begin
      tick();
      @(negedge clk);
      k++;
    end
    checks++;
    if ({res_valid, res_id} !== 3'b100) begin
      failures++; $display("FAIL mrst_after_job: got v=%b id=%0d expected 1/0", res_valid, res_id);
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    bit              busy, e_err;
    int              since, g;
    logic [IDW-1:0]  e_id;
    logic [MW-1:0]   e_hold, e_mat;
    logic [NREQ-1:0] oh;
    bit              ev_vld, ev_en, ev_res;
    do_reset();
    busy = 0; since = 0; e_err = 0; e_id = '0; e_hold = '0; e_mat = '0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) req_mat[k*MW +: MW] = rand_mat(1);
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!busy) begin
        g  = rr_pick(req_valid, last);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        checks++;
        if (req_ready !== oh) begin failures++; $display("FAIL rnd_grant: cycle %0d got %b expected %b", c, req_ready, oh); end
        checks++;
        if ({inv_vld, inv_en, res_valid} !== 3'b000 || inv_mat_in !== e_hold) begin
          failures++; $display("FAIL rnd_idle: cycle %0d got ctrl=%b in=%h", c, {inv_vld, inv_en, res_valid}, inv_mat_in);
        end
        if (g >= 0) begin
          busy   = 1;
          since  = -1;
          last   = g;
          e_id   = IDW'(g);
          e_hold = req_mat[g*MW +: MW];
          e_err  = pivot_bad(e_hold);
          e_mat  = e_err ? '0 : array_fn(e_hold);
        end
      end else begin
        since++;
        ev_vld = !e_err && since <= LAT;
        ev_en  = !e_err && since < LAT;
        ev_res = e_err || since >= LAT + 1;
        checks++;
        if ({req_ready, inv_vld, inv_en, res_valid} !== {{NREQ{1'b0}}, ev_vld, ev_en, ev_res}) begin
          failures++; $display("FAIL rnd_busy_ctrl: cycle %0d got rdy=%b vld=%b en=%b rv=%b expected 0/%b/%b/%b",
                               c, req_ready, inv_vld, inv_en, res_valid, ev_vld, ev_en, ev_res);
        end
        checks++;
        if (inv_mat_in !== e_hold) begin failures++; $display("FAIL rnd_hold: cycle %0d got %h expected %h", c, inv_mat_in, e_hold); end
        if (ev_res) begin
          checks++;
          if ({res_id, res_err, res_mat} !== {e_id, e_err, e_mat}) begin
            failures++; $display("FAIL rnd_result: cycle %0d got id=%0d err=%b mat=%h expected id=%0d err=%b mat=%h",
                                 c, res_id, res_err, res_mat, e_id, e_err, e_mat);
          end
          if (res_ready) busy = 0;
        end
      end
      tick();
    end
    req_valid = '0;
    res_ready = 1'b0;
  endtask

  task automatic test_perf();
    int acc, done_n;
    bit drop;
    logic [15:0] exp_jobs;
    logic [31:0] exp_busy;
    do_reset();
    req_mat[0 +: MW] = rand_mat(0);
    req_valid = 2'b01;
    res_ready = 1'b1;
    acc = 0; done_n = 0; drop = 0;
    for (int c = 0; c < 200 && done_n < 3; c++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) begin
        acc++;
        if (acc == 3) drop = 1;
      end
      if (res_valid && res_ready) done_n++;
      tick();
      if (drop) req_valid = '0;
    end
    checks++;
    if (done_n !== 3) begin failures++; $display("FAIL perf_timeout: got %0d jobs expected 3", done_n); end
    tick();
    @(negedge clk);
`ifdef TRIMAT_SCHED_PERF_EN
    exp_jobs = 16'd3;
    exp_busy = 32'd36;
`else
    exp_jobs = 16'd0;
    exp_busy = 32'd0;
`endif
    checks++;
    if (perf_jobs !== exp_jobs) begin failures++; $display("FAIL perf_jobs: got %0d expected %0d", perf_jobs, exp_jobs); end
    checks++;
    if (perf_busy !== exp_busy) begin failures++; $display("FAIL perf_busy: got %0d expected %0d", perf_busy, exp_busy); end
    res_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_mat   = '0;
    test_reset();
    test_single_job();
    test_alternate();
    test_back_pressure();
    test_reject();
    test_mid_reset();
    test_random();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
